// File: rtl/param_pipe_reg_if.sv
// Lane-sliced stream bundle for param_pipe_reg: producer side, consumer side,
// flush and occupancy. The master modport is the environment driving the
// block; the slave modport is the pipeline register itself.
interface param_pipe_reg_if #(
  parameter int W     = 8,
  parameter int CH    = 4,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [W*CH-1:0]   in_data;
  logic [CH-1:0]     in_chmask;
  logic              out_valid;
  logic              out_ready;
  logic [W*CH-1:0]   out_data;
  logic [CW-1:0]     count;

  modport master (
    output flush, in_valid, in_data, in_chmask, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, in_chmask, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/param_pipe_reg.sv
// CH-lane x W-bit elastic pipeline register, DEPTH stages deep.
// Bubbles collapse: a stage moves forward whenever the stage ahead is empty
// or is itself moving, so in_ready only drops when every stage is full and
// the consumer stalls. Lanes with a clear mask bit are refilled from a
// per-lane memory of the last value written to that lane.
module param_pipe_reg #(
  parameter int             W       = 8,
  parameter int             CH      = 4,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  param_pipe_reg_if.slave     bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [W*CH-1:0]   data_q  [DEPTH];
  logic [W*CH-1:0]   data_d  [DEPTH];
  logic [W-1:0]      last_q  [CH];
  logic [W-1:0]      last_d  [CH];
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  adv_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [W*CH-1:0]   merged_s;

  // Advance chain from the output back to stage 0 (this is the ready path).
  always_comb begin
    adv_s = {DEPTH{1'b0}};
    adv_s[DEPTH-1] = valid_q[DEPTH-1] & bus.out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv_s[k] = valid_q[k] & (~valid_q[k+1] | adv_s[k+1]);
    end
    in_ready_s = ~bus.flush & (~valid_q[0] | adv_s[0]);
    accept_s   = bus.in_valid & in_ready_s;
  end

  // Lane merge of the incoming word and lane-memory update.
  always_comb begin
    merged_s = {(W*CH){1'b0}};
    last_d   = last_q;
    for (int i = 0; i < CH; i++) begin
      if (bus.in_chmask[i]) begin
        merged_s[i*W +: W] = bus.in_data[i*W +: W];
      end else begin
        merged_s[i*W +: W] = last_q[i];
      end
      if (accept_s && bus.in_chmask[i]) begin
        last_d[i] = bus.in_data[i*W +: W];
      end else begin
        last_d[i] = last_q[i];
      end
    end
  end

  // Stage valid/data next state; flush drops every valid bit but moves no data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = {CW{1'b0}};
    if (bus.flush) begin
      valid_d = {DEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        valid_d[0] = 1'b1;
        data_d[0]  = merged_s;
      end else if (adv_s[0]) begin
        valid_d[0] = 1'b0;
      end else begin
        valid_d[0] = valid_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv_s[k-1]) begin
          valid_d[k] = 1'b1;
          data_d[k]  = data_q[k-1];
        end else if (adv_s[k]) begin
          valid_d[k] = 1'b0;
        end else begin
          valid_d[k] = valid_q[k];
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(valid_d[k]);
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= {DEPTH{1'b0}};
      count_q <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= {CH{RST_VAL}};
      end
      for (int i = 0; i < CH; i++) begin
        last_q[i] <= RST_VAL;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_param_pipe_reg.sv
// Bench for param_pipe_reg (W=8, CH=4, DEPTH=2, RST_VAL=0): directed scenarios
// with fixed expected values, then randomized traffic against a queue model.
module tb_param_pipe_reg;
  localparam int W     = 8;
  localparam int CH    = 4;
  localparam int DEPTH = 2;
  localparam logic [W-1:0] RST_VAL = 8'h00;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  param_pipe_reg_if #(.W(W), .CH(CH), .DEPTH(DEPTH)) bus ();

  param_pipe_reg #(.W(W), .CH(CH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words in flight, oldest first, with the stage each occupies.
  logic [W*CH-1:0] q_data [$];
  int              q_stage[$];
  logic [W-1:0]    last_m [CH];

  function automatic bit m_out_valid();
    return (q_stage.size() > 0) && (q_stage[0] == DEPTH - 1);
  endfunction

  function automatic bit m_in_ready();
    return !bus.flush && ((q_data.size() < DEPTH) || bus.out_ready);
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  task automatic tick();
    bit take;
    bit acc;
    int cap;
    int nxt;
    logic [W*CH-1:0] mw;
    @(posedge clk);
    take = m_out_valid() && bus.out_ready;
    acc  = bus.in_valid && m_in_ready();
    if (rst) begin
      q_data.delete();
      q_stage.delete();
      for (int i = 0; i < CH; i++) last_m[i] = RST_VAL;
    end else if (bus.flush) begin
      q_data.delete();
      q_stage.delete();
    end else begin
      if (take) begin
        void'(q_data.pop_front());
        void'(q_stage.pop_front());
      end
      for (int j = 0; j < q_stage.size(); j++) begin
        cap = (j == 0) ? DEPTH - 1 : q_stage[j-1] - 1;
        nxt = q_stage[j] + 1;
        q_stage[j] = (nxt < cap) ? nxt : cap;
      end
      if (acc) begin
        for (int i = 0; i < CH; i++) begin
          mw[i*W +: W] = bus.in_chmask[i] ? bus.in_data[i*W +: W] : last_m[i];
          if (bus.in_chmask[i]) last_m[i] = bus.in_data[i*W +: W];
        end
        q_data.push_back(mw);
        q_stage.push_back(0);
      end
    end
  endtask

  // One cycle: pass the edge, drive new inputs on the falling edge, let them settle.
  task automatic set_in(input bit r, input bit f, input bit iv, input logic [31:0] d,
                        input logic [3:0] m, input bit ordy);
    tick();
    @(negedge clk);
    rst           = r;
    bus.flush     = f;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_chmask = m;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 00000000", bus.out_data); end
    n_cmp++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_streaming();
    set_in(1'b0, 1'b0, 1'b1, 32'h11223344, 4'hF, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_rdy1 got %b want 1", bus.in_ready); end
    set_in(1'b0, 1'b0, 1'b1, 32'h55667788, 4'hF, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_rdy2 got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL stream_count1 got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_ov1 got %b want 0", bus.out_valid); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11223344) begin n_err++; $display("FAIL stream_word1 got %b/%h want 1/11223344", bus.out_valid, bus.out_data); end
    n_cmp++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL stream_count2 got %0d want 2", bus.count); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55667788) begin n_err++; $display("FAIL stream_word2 got %b/%h want 1/55667788", bus.out_valid, bus.out_data); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %0d/%b want 0/0", bus.count, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    set_in(1'b0, 1'b0, 1'b1, 32'h01, 4'hF, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 32'h02, 4'hF, 1'b0);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy_half got %b want 1", bus.in_ready); end
    set_in(1'b0, 1'b0, 1'b1, 32'h03, 4'hF, 1'b0);
    n_cmp++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL bp_count_full got %0d want 2", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy_full got %b want 0", bus.in_ready); end
    set_in(1'b0, 1'b0, 1'b1, 32'h03, 4'hF, 1'b0);
    n_cmp++; if (bus.out_data !== 32'h01 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stable got %h/%b want 00000001/0", bus.out_data, bus.in_ready); end
    set_in(1'b0, 1'b0, 1'b1, 32'h03, 4'hF, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_data !== 32'h01) begin n_err++; $display("FAIL bp_full_pass got %b/%h want 1/00000001", bus.in_ready, bus.out_data); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_data !== 32'h02 || bus.count !== 2'd2) begin n_err++; $display("FAIL bp_word2 got %h/%0d want 00000002/2", bus.out_data, bus.count); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_data !== 32'h03 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_word3 got %h/%b want 00000003/1", bus.out_data, bus.out_valid); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL bp_empty got %0d want 0", bus.count); end
  endtask

  task automatic test_lane_merge();
    set_in(1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 4'b1111, 1'b1);
    set_in(1'b0, 1'b0, 1'b1, 32'h11223344, 4'b0101, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_data !== 32'hAABBCCDD) begin n_err++; $display("FAIL merge_word1 got %h want aabbccdd", bus.out_data); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAA22CC44) begin n_err++; $display("FAIL merge_word2 got %b/%h want 1/aa22cc44", bus.out_valid, bus.out_data); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
  endtask

  task automatic test_flush();
    set_in(1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0);
    set_in(1'b0, 1'b1, 1'b1, 32'h99, 4'hF, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.count !== 2'd2) begin n_err++; $display("FAIL flush_pre got %b/%0d want 1/2", bus.out_valid, bus.count); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear got %0d/%b want 0/0", bus.count, bus.out_valid); end
    set_in(1'b0, 1'b0, 1'b1, 32'h12345678, 4'b0001, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL flush_no99 got %0d want 1", bus.count); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAABBCC78) begin n_err++; $display("FAIL flush_lanemem got %b/%h want 1/aabbcc78", bus.out_valid, bus.out_data); end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0);
    set_in(1'b1, 1'b0, 1'b1, 32'h55, 4'hF, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_empty got %0d/%b want 0/0", bus.count, bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_data got %h/%b want 00000000/1", bus.out_data, bus.in_ready); end
    set_in(1'b0, 1'b0, 1'b1, 32'h000000FF, 4'b0001, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h000000FF) begin n_err++; $display("FAIL rmid_push got %b/%h want 1/000000ff", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_random();
    bit r;
    bit f;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 5);
      set_in(r, f, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 6));
      n_cmp++; if (bus.in_ready !== m_in_ready()) begin n_err++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", n, bus.in_ready, m_in_ready()); end
      n_cmp++; if (bus.out_valid !== m_out_valid()) begin n_err++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", n, bus.out_valid, m_out_valid()); end
      n_cmp++; if (bus.count !== 2'(q_data.size())) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, bus.count, q_data.size()); end
      if (m_out_valid()) begin
        n_cmp++; if (bus.out_data !== q_data[0]) begin n_err++; $display("FAIL rnd_out_data cyc %0d got %h want %h", n, bus.out_data, q_data[0]); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_chmask = 4'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < CH; i++) last_m[i] = RST_VAL;
    test_reset();
    test_streaming();
    test_backpressure();
    test_lane_merge();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
